// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, access sizes and
// requesting-port identifiers.
package mem_arb_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      RESP  = 2'b11
   } state_t;

   // Access size codes as presented on d_size; SZ_R is reserved and always errors
   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_R = 2'b11
   } size_t;

   // Requesting port identifiers
   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_t;

endpackage : mem_arb_pkg

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port (i_*), load/store port (d_*) and memory macro
// (mem_*) signals around the arbiter.
//   slave  : the arbiter (receives requests and mem_rdata, drives acks and mem commands)
//   master : the core + memory side (drives requests and mem_rdata)
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 30
) ();
   logic              i_req;
   logic [31:0]       i_addr;
   logic              i_ack;
   logic [31:0]       i_rdata;
   logic              i_err;

   logic              d_req;
   logic              d_we;
   logic [1:0]        d_size;
   logic              d_signed;
   logic [31:0]       d_addr;
   logic [31:0]       d_wdata;
   logic              d_ack;
   logic [31:0]       d_rdata;
   logic              d_err;

   logic              mem_en;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_size, d_signed, d_addr, d_wdata, mem_rdata,
      output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
             mem_en, mem_we, mem_be, mem_addr, mem_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_size, d_signed, d_addr, d_wdata, mem_rdata,
      input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
             mem_en, mem_we, mem_be, mem_addr, mem_wdata
   );
endinterface : mem_port_arbiter_if

// File: rtl/mem_lane.sv
// Byte-lane steering for one access (purely combinational).
//   addr_lo_i  : byte offset within the word
//   size_i     : access size
//   signed_i   : sign-extend sub-word loads
//   wdata_i    : right-justified store data
//   rdata_i    : raw memory word
//   be_o       : store byte enables (0 when misaligned)
//   wdata_o    : store data replicated across all lanes
//   rdata_o    : extracted and extended load data (0 when misaligned)
//   misalign_o : access is misaligned or uses the reserved size
module mem_lane
   import mem_arb_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  size_t       size_i,
   input  logic        signed_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        misalign_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Pick the addressed byte and the addressed (aligned) half-word out of the read word
   always_comb begin
      byte_s = rdata_i[{addr_lo_i, 3'b000} +: 8];
      half_s = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
   end

   // Per-size enables, store replication, load extension and alignment check
   always_comb begin
      be_o       = 4'b0000;
      wdata_o    = 32'h0000_0000;
      rdata_o    = 32'h0000_0000;
      misalign_o = 1'b0;
      case (size_i)
         SZ_B: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{signed_i & byte_s[7]}}, byte_s};
         end
         SZ_H: begin
            misalign_o = addr_lo_i[0];
            if (addr_lo_i[0]) begin
               be_o = 4'b0000;
            end else begin
               be_o    = 4'b0011 << addr_lo_i;
               wdata_o = {2{wdata_i[15:0]}};
               rdata_o = {{16{signed_i & half_s[15]}}, half_s};
            end
         end
         SZ_W: begin
            misalign_o = (addr_lo_i != 2'b00);
            if (addr_lo_i != 2'b00) begin
               be_o = 4'b0000;
            end else begin
               be_o    = 4'b1111;
               wdata_o = wdata_i;
               rdata_o = rdata_i;
            end
         end
         default: begin
            misalign_o = 1'b1;
         end
      endcase
   end

endmodule : mem_lane

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between the
// instruction-fetch port and the load/store port, one transaction at a time.
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high; aborts any transaction, all outputs 0
//   bus   : slave side of mem_port_arbiter_if (i_*, d_* request/ack ports and mem_* macro port)
// Parameters: ADDR_W word-address width, RD_LAT memory read latency (>= 1).
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 30,
   parameter int RD_LAT = 1
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);

   localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

   state_t             state_q;
   port_t              last_grant_q;
   port_t              port_q;
   logic [1:0]         addr_lo_q;
   logic               we_q;
   size_t              size_q;
   logic               signed_q;
   logic               err_q;
   logic [CNT_W-1:0]   cnt_q;

   logic               grant_vld_s;
   port_t              grant_s;
   logic [31:0]        sel_addr_s;
   logic               sel_we_s;
   size_t              sel_size_s;
   logic               sel_signed_s;
   logic [31:0]        sel_wdata_s;

   logic [1:0]         lane_addr_s;
   size_t              lane_size_s;
   logic               lane_signed_s;
   logic [31:0]        lane_wdata_s;
   logic [3:0]         lane_be_s;
   logic [31:0]        lane_wd_s;
   logic [31:0]        lane_rd_s;
   logic               lane_mis_s;

   // Round-robin choice: on a tie the port that did not win last time goes next
   always_comb begin
      grant_vld_s = bus.i_req | bus.d_req;
      if (bus.i_req && bus.d_req) begin
         grant_s = (last_grant_q == PORT_D) ? PORT_I : PORT_D;
      end else if (bus.i_req) begin
         grant_s = PORT_I;
      end else begin
         grant_s = PORT_D;
      end
   end

   // Request fields of the winning port; a fetch is an unsigned word load
   always_comb begin
      if (grant_s == PORT_I) begin
         sel_addr_s   = bus.i_addr;
         sel_we_s     = 1'b0;
         sel_size_s   = SZ_W;
         sel_signed_s = 1'b0;
         sel_wdata_s  = 32'h0000_0000;
      end else begin
         sel_addr_s   = bus.d_addr;
         sel_we_s     = bus.d_we;
         sel_size_s   = size_t'(bus.d_size);
         sel_signed_s = bus.d_signed;
         sel_wdata_s  = bus.d_wdata;
      end
   end

   // The lane logic sees the live request while granting and the captured fields afterwards
   always_comb begin
      if (state_q == IDLE) begin
         lane_addr_s   = sel_addr_s[1:0];
         lane_size_s   = sel_size_s;
         lane_signed_s = sel_signed_s;
         lane_wdata_s  = sel_wdata_s;
      end else begin
         lane_addr_s   = addr_lo_q;
         lane_size_s   = size_q;
         lane_signed_s = signed_q;
         lane_wdata_s  = 32'h0000_0000;
      end
   end

   mem_lane u_lane (
      .addr_lo_i  (lane_addr_s),
      .size_i     (lane_size_s),
      .signed_i   (lane_signed_s),
      .wdata_i    (lane_wdata_s),
      .rdata_i    (bus.mem_rdata),
      .be_o       (lane_be_s),
      .wdata_o    (lane_wd_s),
      .rdata_o    (lane_rd_s),
      .misalign_o (lane_mis_s)
   );

   // Arbiter FSM with registered memory command, latency counter and response outputs.
   // The memory command is loaded on the grant edge so it is presented during ISSUE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         last_grant_q  <= PORT_D;
         port_q        <= PORT_I;
         addr_lo_q     <= 2'b00;
         we_q          <= 1'b0;
         size_q        <= SZ_B;
         signed_q      <= 1'b0;
         err_q         <= 1'b0;
         cnt_q         <= CNT_W'(0);
         bus.i_ack     <= 1'b0;
         bus.i_rdata   <= 32'h0000_0000;
         bus.i_err     <= 1'b0;
         bus.d_ack     <= 1'b0;
         bus.d_rdata   <= 32'h0000_0000;
         bus.d_err     <= 1'b0;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_be    <= 4'b0000;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= 32'h0000_0000;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_vld_s) begin
                  port_q        <= grant_s;
                  last_grant_q  <= grant_s;
                  addr_lo_q     <= sel_addr_s[1:0];
                  we_q          <= sel_we_s;
                  size_q        <= sel_size_s;
                  signed_q      <= sel_signed_s;
                  err_q         <= lane_mis_s;
                  // An erroneous access never reaches the memory
                  bus.mem_en    <= ~lane_mis_s;
                  bus.mem_we    <= ~lane_mis_s & sel_we_s;
                  bus.mem_be    <= lane_mis_s ? 4'b0000 : (sel_we_s ? lane_be_s : 4'b1111);
                  bus.mem_addr  <= lane_mis_s ? '0 : sel_addr_s[ADDR_W+1:2];
                  bus.mem_wdata <= (lane_mis_s || !sel_we_s) ? 32'h0000_0000 : lane_wd_s;
                  state_q       <= ISSUE;
               end else begin
                  state_q <= IDLE;
               end
            end
            ISSUE: begin
               bus.mem_en    <= 1'b0;
               bus.mem_we    <= 1'b0;
               bus.mem_be    <= 4'b0000;
               bus.mem_addr  <= '0;
               bus.mem_wdata <= 32'h0000_0000;
               if (err_q || we_q) begin
                  // Stores and errors answer immediately with zero data
                  if (port_q == PORT_I) begin
                     bus.i_ack <= 1'b1;
                     bus.i_err <= err_q;
                  end else begin
                     bus.d_ack <= 1'b1;
                     bus.d_err <= err_q;
                  end
                  state_q <= RESP;
               end else begin
                  cnt_q   <= CNT_W'(1);
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q == CNT_W'(RD_LAT)) begin
                  if (port_q == PORT_I) begin
                     bus.i_ack   <= 1'b1;
                     bus.i_rdata <= lane_rd_s;
                  end else begin
                     bus.d_ack   <= 1'b1;
                     bus.d_rdata <= lane_rd_s;
                  end
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            RESP: begin
               bus.i_ack   <= 1'b0;
               bus.i_rdata <= 32'h0000_0000;
               bus.i_err   <= 1'b0;
               bus.d_ack   <= 1'b0;
               bus.d_rdata <= 32'h0000_0000;
               bus.d_err   <= 1'b0;
               state_q     <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (RD_LAT = 1). Expected responses are
// queued when a request is driven and popped when an ack is observed.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(30)) bus ();

   mem_port_arbiter #(.ADDR_W(30), .RD_LAT(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Memory model with one cycle read latency; contents only written by the stimulus
   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr[7:0]];
   end

   typedef struct packed {
      logic        port;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Observations from the most recent collect_resp call
   logic        r_port;
   logic [31:0] r_rdata;
   logic        r_err;
   int          r_lat;
   int          r_en_cnt;
   int          r_en_cyc;
   logic [29:0] r_maddr;
   logic [3:0]  r_be;
   logic [31:0] r_wd;
   logic        r_we;
   logic        r_to;
   logic        r_xbad;
   exp_t        e;
   logic        e_ok;

   // Watch the bus until the next ack (bounded); records memory commands seen on the way
   task automatic collect_resp();
      r_lat = 0; r_en_cnt = 0; r_en_cyc = -1; r_to = 1'b1; r_xbad = 1'b0;
      r_port = 1'b0; r_rdata = 32'h0; r_err = 1'b0;
      r_maddr = 30'h0; r_be = 4'h0; r_wd = 32'h0; r_we = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.mem_en) begin
            r_en_cnt++; r_en_cyc = k;
            r_maddr = bus.mem_addr; r_be = bus.mem_be; r_wd = bus.mem_wdata; r_we = bus.mem_we;
         end
         if (bus.i_ack || bus.d_ack) begin
            r_to    = 1'b0;
            r_lat   = k;
            r_port  = bus.d_ack;
            r_rdata = bus.d_ack ? bus.d_rdata : bus.i_rdata;
            r_err   = bus.d_ack ? bus.d_err : bus.i_err;
            r_xbad  = (bus.i_ack && bus.d_ack) ||
                      (bus.d_ack ? (bus.i_rdata != 32'h0 || bus.i_err) : (bus.d_rdata != 32'h0 || bus.d_err));
            break;
         end
      end
   endtask

   task automatic pop_exp();
      e_ok = (exp_q.size() != 0);
      if (e_ok) e = exp_q.pop_front();
      else e = '0;
   endtask

   task automatic drive_d(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd);
      bus.d_we = we; bus.d_size = sz; bus.d_signed = sg; bus.d_addr = a; bus.d_wdata = wd;
      bus.d_req = 1'b1;
   endtask

   task automatic drop_reqs();
      @(posedge clk); #1;
      bus.i_req = 1'b0; bus.d_req = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.i_req = 1'b0; bus.i_addr = 32'h0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 2'b00; bus.d_signed = 1'b0;
      bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({bus.i_ack, bus.i_rdata, bus.i_err, bus.d_ack, bus.d_rdata, bus.d_err} !== 68'h0) begin
         n_bad++; $display("FAIL reset_resp: got %h want 0", {bus.i_ack, bus.i_rdata, bus.i_err, bus.d_ack, bus.d_rdata, bus.d_err});
      end
      n_cmp++;
      if ({bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== 68'h0) begin
         n_bad++; $display("FAIL reset_mem: got %h want 0", {bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata});
      end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_single_fetch();
      mem[8'h40] = 32'h8C22_0004;
      @(posedge clk); #1;
      bus.i_addr = 32'h0000_0100; bus.i_req = 1'b1;
      exp_q.push_back({1'b0, 32'h8C22_0004, 1'b0});
      collect_resp();
      drop_reqs();
      pop_exp();
      n_cmp++;
      if (r_to || !e_ok || {r_port, r_rdata, r_err} !== e) begin
         n_bad++; $display("FAIL fetch_resp: got to=%0b port=%0b rdata=%h err=%0b want port=%0b rdata=%h err=%0b", r_to, r_port, r_rdata, r_err, e.port, e.rdata, e.err);
      end
      n_cmp++;
      if (r_lat != 3 || r_en_cnt != 1 || r_en_cyc != 1) begin
         n_bad++; $display("FAIL fetch_timing: got ack=%0d en_cnt=%0d en_cyc=%0d want ack=3 en_cnt=1 en_cyc=1", r_lat, r_en_cnt, r_en_cyc);
      end
      n_cmp++;
      if (r_maddr !== 30'h40 || r_be !== 4'hF || r_we !== 1'b0 || r_xbad) begin
         n_bad++; $display("FAIL fetch_cmd: got addr=%h be=%b we=%b xbad=%b want addr=40 be=1111 we=0 xbad=0", r_maddr, r_be, r_we, r_xbad);
      end
   endtask

   task automatic test_tie();
      mem[8'h41] = 32'h1111_2222;
      mem[8'h82] = 32'h3333_4444;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      bus.i_addr = 32'h0000_0104; bus.i_req = 1'b1;
      drive_d(1'b0, 2'b10, 1'b0, 32'h0000_0208, 32'h0);
      for (int n = 0; n < 2; n++) begin
         exp_q.push_back({1'b0, 32'h1111_2222, 1'b0});
         exp_q.push_back({1'b1, 32'h3333_4444, 1'b0});
      end
      for (int n = 0; n < 4; n++) begin
         collect_resp();
         pop_exp();
         n_cmp++;
         if (r_to || !e_ok || r_xbad || {r_port, r_rdata, r_err} !== e) begin
            n_bad++; $display("FAIL tie_order[%0d]: got to=%0b port=%0b rdata=%h err=%0b want port=%0b rdata=%h err=%0b", n, r_to, r_port, r_rdata, r_err, e.port, e.rdata, e.err);
         end
      end
      drop_reqs();
   endtask

   task automatic test_stores();
      logic [1:0]  sz [2] = '{2'b00, 2'b01};
      logic [31:0] ad [2] = '{32'h0000_0203, 32'h0000_0202};
      logic [31:0] wd [2] = '{32'h0000_00A5, 32'h1234_BEEF};
      logic [3:0]  xb [2] = '{4'b1000, 4'b1100};
      logic [31:0] xw [2] = '{32'hA5A5_A5A5, 32'hBEEF_BEEF};
      for (int n = 0; n < 2; n++) begin
         @(posedge clk); #1;
         drive_d(1'b1, sz[n], 1'b0, ad[n], wd[n]);
         exp_q.push_back({1'b1, 32'h0, 1'b0});
         collect_resp();
         drop_reqs();
         pop_exp();
         n_cmp++;
         if (r_to || !e_ok || {r_port, r_rdata, r_err} !== e || r_lat != 2) begin
            n_bad++; $display("FAIL store_resp[%0d]: got to=%0b port=%0b rdata=%h err=%0b ack=%0d want port=1 rdata=0 err=0 ack=2", n, r_to, r_port, r_rdata, r_err, r_lat);
         end
         n_cmp++;
         if (r_en_cyc != 1 || r_maddr !== 30'h80 || r_be !== xb[n] || r_wd !== xw[n] || r_we !== 1'b1) begin
            n_bad++; $display("FAIL store_cmd[%0d]: got cyc=%0d addr=%h be=%b wdata=%h we=%b want cyc=1 addr=80 be=%b wdata=%h we=1", n, r_en_cyc, r_maddr, r_be, r_wd, r_we, xb[n], xw[n]);
         end
      end
   endtask

   task automatic test_loads();
      logic [1:0]  sz [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
      logic        sg [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic [31:0] ad [6] = '{32'h243, 32'h243, 32'h242, 32'h242, 32'h241, 32'h240};
      logic [31:0] xr [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF,
                              32'h0000_007F, 32'h0000_7F00};
      mem[8'h90] = 32'h80FF_7F00;
      for (int n = 0; n < 6; n++) begin
         @(posedge clk); #1;
         drive_d(1'b0, sz[n], sg[n], ad[n], 32'hDEAD_BEEF);
         exp_q.push_back({1'b1, xr[n], 1'b0});
         collect_resp();
         drop_reqs();
         pop_exp();
         n_cmp++;
         if (r_to || !e_ok || r_xbad || {r_port, r_rdata, r_err} !== e || r_lat != 3) begin
            n_bad++; $display("FAIL load_resp[%0d]: got to=%0b port=%0b rdata=%h err=%0b ack=%0d want port=%0b rdata=%h err=%0b ack=3", n, r_to, r_port, r_rdata, r_err, r_lat, e.port, e.rdata, e.err);
         end
         n_cmp++;
         if (r_en_cnt != 1 || r_maddr !== 30'h90 || r_be !== 4'hF || r_we !== 1'b0) begin
            n_bad++; $display("FAIL load_cmd[%0d]: got en_cnt=%0d addr=%h be=%b we=%b want en_cnt=1 addr=90 be=1111 we=0", n, r_en_cnt, r_maddr, r_be, r_we);
         end
      end
   endtask

   task automatic test_misaligned();
      logic        pi [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic        we [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      logic [1:0]  sz [4] = '{2'b10, 2'b11, 2'b01, 2'b10};
      logic [31:0] ad [4] = '{32'h202, 32'h200, 32'h201, 32'h102};
      for (int n = 0; n < 4; n++) begin
         @(posedge clk); #1;
         if (pi[n]) begin
            bus.i_addr = ad[n]; bus.i_req = 1'b1;
         end else begin
            drive_d(we[n], sz[n], 1'b1, ad[n], 32'h5555_AAAA);
         end
         exp_q.push_back({~pi[n], 32'h0, 1'b1});
         collect_resp();
         drop_reqs();
         pop_exp();
         n_cmp++;
         if (r_to || !e_ok || r_xbad || {r_port, r_rdata, r_err} !== e || r_lat != 2 || r_en_cnt != 0) begin
            n_bad++; $display("FAIL misalign[%0d]: got to=%0b port=%0b rdata=%h err=%0b ack=%0d en_cnt=%0d want port=%0b rdata=0 err=1 ack=2 en_cnt=0", n, r_to, r_port, r_rdata, r_err, r_lat, r_en_cnt, e.port);
         end
      end
   endtask

   task automatic test_reset_in_wait();
      @(posedge clk); #1;
      drive_d(1'b0, 2'b10, 1'b0, 32'h0000_0240, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if ({bus.i_ack, bus.i_rdata, bus.i_err, bus.d_ack, bus.d_rdata, bus.d_err} !== 68'h0) begin
         n_bad++; $display("FAIL abort_resp: got %h want 0", {bus.i_ack, bus.i_rdata, bus.i_err, bus.d_ack, bus.d_rdata, bus.d_err});
      end
      n_cmp++;
      if ({bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== 68'h0) begin
         n_bad++; $display("FAIL abort_mem: got %h want 0", {bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata});
      end
      @(posedge clk); #1;
      reset = 1'b0;
      bus.i_addr = 32'h0000_0100; bus.i_req = 1'b1;
      exp_q.push_back({1'b0, 32'h8C22_0004, 1'b0});
      exp_q.push_back({1'b1, 32'h80FF_7F00, 1'b0});
      for (int n = 0; n < 2; n++) begin
         collect_resp();
         if (n == 1) drop_reqs();
         pop_exp();
         n_cmp++;
         if (r_to || !e_ok || r_xbad || {r_port, r_rdata, r_err} !== e) begin
            n_bad++; $display("FAIL post_reset_tie[%0d]: got to=%0b port=%0b rdata=%h err=%0b want port=%0b rdata=%h err=%0b", n, r_to, r_port, r_rdata, r_err, e.port, e.rdata, e.err);
         end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_tie();
      test_stores();
      test_loads();
      test_misaligned();
      test_reset_in_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish before 200000");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_mem_port_arbiter
